// File: rtl/pixel_dispatch_scheduler.sv
// Round-robin pixel dispatcher: hands raster coordinates to NUM_ENGINES compute engines
// and re-serialises their results into a strict raster-order output stream.
module pixel_dispatch_scheduler #(
    parameter int DATA_WIDTH    = 32,
    parameter int RGB_SIZE      = 24,
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int NUM_ENGINES   = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    output logic                            busy,
    output logic                            frame_done,
    output logic [NUM_ENGINES-1:0]          eng_start,
    output logic [DATA_WIDTH-1:0]           eng_x,
    output logic [DATA_WIDTH-1:0]           eng_y,
    input  logic [NUM_ENGINES-1:0]          eng_done,
    input  logic [NUM_ENGINES*RGB_SIZE-1:0] eng_colour,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [RGB_SIZE-1:0]             out_colour,
    output logic                            out_first,
    output logic                            out_last_x,
    output logic                            out_last_y
);
    localparam int PTR_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
    localparam logic [DATA_WIDTH-1:0] X_LAST   = DATA_WIDTH'(SCREEN_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] Y_LAST   = DATA_WIDTH'(SCREEN_HEIGHT - 1);
    localparam logic [PTR_W-1:0]      PTR_LAST = PTR_W'(NUM_ENGINES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;
    typedef enum logic [1:0] {SLOT_EMPTY, SLOT_BUSY, SLOT_FULL} slot_t;

    state_t                state_q, state_d;
    slot_t                 slot_q   [NUM_ENGINES];
    slot_t                 slot_d   [NUM_ENGINES];
    logic [RGB_SIZE-1:0]   colour_q [NUM_ENGINES];
    logic [RGB_SIZE-1:0]   colour_d [NUM_ENGINES];
    logic [RGB_SIZE-1:0]   eng_colour_w [NUM_ENGINES];

    logic [PTR_W-1:0]      disp_ptr_q, disp_ptr_d, ret_ptr_q, ret_ptr_d;
    logic [DATA_WIDTH-1:0] disp_x_q, disp_x_d, disp_y_q, disp_y_d;
    logic [DATA_WIDTH-1:0] ret_x_q, ret_x_d, ret_y_q, ret_y_d;
    logic [NUM_ENGINES-1:0] eng_start_q, eng_start_d;
    logic [DATA_WIDTH-1:0] eng_x_q, eng_x_d, eng_y_q, eng_y_d;
    logic                  out_valid_q, out_valid_d;
    logic [RGB_SIZE-1:0]   out_colour_q, out_colour_d;
    logic                  out_first_q, out_first_d;
    logic                  out_last_x_q, out_last_x_d;
    logic                  out_last_y_q, out_last_y_d;
    logic                  busy_q, busy_d;
    logic                  frame_done_q, frame_done_d;
    logic                  dispatch, transfer;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    for (genvar gi = 0; gi < NUM_ENGINES; gi++) begin : g_slice
        assign eng_colour_w[gi] = eng_colour[gi*RGB_SIZE +: RGB_SIZE];
    end

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        colour_d    = colour_q;
        disp_ptr_d  = disp_ptr_q;
        ret_ptr_d   = ret_ptr_q;
        disp_x_d    = disp_x_q;
        disp_y_d    = disp_y_q;
        ret_x_d     = ret_x_q;
        ret_y_d     = ret_y_q;
        eng_start_d = '0;
        eng_x_d     = eng_x_q;
        eng_y_d     = eng_y_q;
        dispatch    = (state_q == ST_RUN) && (slot_q[disp_ptr_q] == SLOT_EMPTY);
        transfer    = out_valid_q && out_ready;

        // A strobe coinciding with the engine's own start pulse belongs to no live job.
        for (int k = 0; k < NUM_ENGINES; k++) begin
            if ((slot_q[k] == SLOT_BUSY) && eng_done[k] && !eng_start_q[k]) begin
                slot_d[k]   = SLOT_FULL;
                colour_d[k] = eng_colour_w[k];
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_RUN;
                    disp_ptr_d = '0;
                    ret_ptr_d  = '0;
                    disp_x_d   = '0;
                    disp_y_d   = '0;
                    ret_x_d    = '0;
                    ret_y_d    = '0;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: ;
        endcase

        if (dispatch) begin
            slot_d[disp_ptr_q]      = SLOT_BUSY;
            eng_start_d[disp_ptr_q] = 1'b1;
            eng_x_d                 = disp_x_q;
            eng_y_d                 = disp_y_q;
            disp_ptr_d              = ptr_inc(disp_ptr_q);
            if (disp_x_q == X_LAST) begin
                disp_x_d = '0;
                disp_y_d = disp_y_q + DATA_WIDTH'(1);
                if (disp_y_q == Y_LAST)
                    state_d = ST_DRAIN;
            end else begin
                disp_x_d = disp_x_q + DATA_WIDTH'(1);
            end
        end

        if (transfer) begin
            slot_d[ret_ptr_q] = SLOT_EMPTY;
            ret_ptr_d         = ptr_inc(ret_ptr_q);
            if (ret_x_q == X_LAST) begin
                ret_x_d = '0;
                ret_y_d = ret_y_q + DATA_WIDTH'(1);
            end else begin
                ret_x_d = ret_x_q + DATA_WIDTH'(1);
            end
            if (out_last_y_q)
                state_d = ST_DONE;
        end

        // Outputs are registered images of the next-cycle state.
        out_valid_d  = (slot_d[ret_ptr_d] == SLOT_FULL) &&
                       ((state_d == ST_RUN) || (state_d == ST_DRAIN));
        out_colour_d = colour_d[ret_ptr_d];
        out_first_d  = out_valid_d && (ret_x_d == '0) && (ret_y_d == '0);
        out_last_x_d = out_valid_d && (ret_x_d == X_LAST);
        out_last_y_d = out_valid_d && (ret_x_d == X_LAST) && (ret_y_d == Y_LAST);
        busy_d       = (state_d != ST_IDLE);
        frame_done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            for (int k = 0; k < NUM_ENGINES; k++) begin
                slot_q[k]   <= SLOT_EMPTY;
                colour_q[k] <= '0;
            end
            disp_ptr_q   <= '0;
            ret_ptr_q    <= '0;
            disp_x_q     <= '0;
            disp_y_q     <= '0;
            ret_x_q      <= '0;
            ret_y_q      <= '0;
            eng_start_q  <= '0;
            eng_x_q      <= '0;
            eng_y_q      <= '0;
            out_valid_q  <= 1'b0;
            out_colour_q <= '0;
            out_first_q  <= 1'b0;
            out_last_x_q <= 1'b0;
            out_last_y_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            colour_q     <= colour_d;
            disp_ptr_q   <= disp_ptr_d;
            ret_ptr_q    <= ret_ptr_d;
            disp_x_q     <= disp_x_d;
            disp_y_q     <= disp_y_d;
            ret_x_q      <= ret_x_d;
            ret_y_q      <= ret_y_d;
            eng_start_q  <= eng_start_d;
            eng_x_q      <= eng_x_d;
            eng_y_q      <= eng_y_d;
            out_valid_q  <= out_valid_d;
            out_colour_q <= out_colour_d;
            out_first_q  <= out_first_d;
            out_last_x_q <= out_last_x_d;
            out_last_y_q <= out_last_y_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign eng_start  = eng_start_q;
    assign eng_x      = eng_x_q;
    assign eng_y      = eng_y_q;
    assign out_valid  = out_valid_q;
    assign out_colour = out_colour_q;
    assign out_first  = out_first_q;
    assign out_last_x = out_last_x_q;
    assign out_last_y = out_last_y_q;

endmodule

// File: tb/tb_pixel_dispatch_scheduler.sv
// Directed bench for pixel_dispatch_scheduler on an 8x2 screen, with a 4-engine and a 1-engine instance
// driven by a per-cycle engine model whose results are checked against raster-order expectations.
module tb_pixel_dispatch_scheduler;
    localparam int DW  = 32;
    localparam int RGB = 24;
    localparam int SW  = 8;
    localparam int SH  = 2;
    localparam logic [RGB-1:0] JUNK = 24'hBADBAD;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic start1 = 1'b0;
    logic out_ready = 1'b0;
    always #5 clk = ~clk;

    logic            busy, frame_done, out_valid, out_first, out_last_x, out_last_y;
    logic [3:0]      eng_start;
    logic [3:0]      eng_done = '0;
    logic [DW-1:0]   eng_x, eng_y;
    logic [4*RGB-1:0] eng_colour = '0;
    logic [RGB-1:0]  out_colour;

    logic            busy1, frame_done1, out_valid1, out_first1, out_last_x1, out_last_y1;
    logic [0:0]      eng_start1;
    logic [0:0]      eng_done1 = '0;
    logic [DW-1:0]   eng_x1, eng_y1;
    logic [RGB-1:0]  eng_colour1 = '0;
    logic [RGB-1:0]  out_colour1;

    pixel_dispatch_scheduler #(.DATA_WIDTH(DW), .RGB_SIZE(RGB), .SCREEN_WIDTH(SW),
                               .SCREEN_HEIGHT(SH), .NUM_ENGINES(4)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .frame_done(frame_done),
        .eng_start(eng_start), .eng_x(eng_x), .eng_y(eng_y), .eng_done(eng_done),
        .eng_colour(eng_colour), .out_valid(out_valid), .out_ready(out_ready),
        .out_colour(out_colour), .out_first(out_first), .out_last_x(out_last_x),
        .out_last_y(out_last_y)
    );

    pixel_dispatch_scheduler #(.DATA_WIDTH(DW), .RGB_SIZE(RGB), .SCREEN_WIDTH(SW),
                               .SCREEN_HEIGHT(SH), .NUM_ENGINES(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .busy(busy1), .frame_done(frame_done1),
        .eng_start(eng_start1), .eng_x(eng_x1), .eng_y(eng_y1), .eng_done(eng_done1),
        .eng_colour(eng_colour1), .out_valid(out_valid1), .out_ready(out_ready),
        .out_colour(out_colour1), .out_first(out_first1), .out_last_x(out_last_x1),
        .out_last_y(out_last_y1)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int sel = 0;
    int beat_n = 0;
    int fd_cnt = 0;
    int start_cnt = 0;
    logic [7:0] tag = '0;
    int dly [4];
    int cnt [4];
    logic [RGB-1:0] code [4];
    logic [3:0] inj_mask = '0;
    logic [3:0] junk_start = '0;
    logic s_valid, s_first, s_lx, s_ly, s_fd, s_busy;
    logic [RGB-1:0] s_col;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic sample();
        if (sel != 0) begin
            s_valid = out_valid1; s_col = out_colour1; s_first = out_first1;
            s_lx = out_last_x1; s_ly = out_last_y1; s_fd = frame_done1; s_busy = busy1;
        end else begin
            s_valid = out_valid; s_col = out_colour; s_first = out_first;
            s_lx = out_last_x; s_ly = out_last_y; s_fd = frame_done; s_busy = busy;
        end
    endtask

    // Engine model: a start seen this cycle schedules a result dly[k] cycles later.
    task automatic eng_update();
        logic [3:0] es, dn;
        logic [DW-1:0] ex, ey;
        logic [RGB-1:0] col [4];
        es = (sel != 0) ? {3'b000, eng_start1} : eng_start;
        ex = (sel != 0) ? eng_x1 : eng_x;
        ey = (sel != 0) ? eng_y1 : eng_y;
        dn = inj_mask;
        for (int k = 0; k < 4; k++) begin
            col[k] = JUNK;
            if (cnt[k] > 0) begin
                cnt[k]--;
                if (cnt[k] == 0) begin
                    dn[k]  = 1'b1;
                    col[k] = code[k];
                end
            end
            if (es[k]) begin
                start_cnt++;
                code[k] = {tag, ey[7:0], ex[7:0]};
                cnt[k]  = dly[k];
                if (junk_start[k]) begin
                    dn[k] = 1'b1;
                    junk_start[k] = 1'b0;
                end
            end
        end
        if (sel != 0) begin
            eng_done1   = dn[0:0];
            eng_colour1 = col[0];
        end else begin
            eng_done   = dn;
            eng_colour = {col[3], col[2], col[1], col[0]};
        end
    endtask

    // Checks this cycle's beat (if transferred), then advances one clock.
    task automatic step();
        int bx, by;
        sample();
        if (s_fd) fd_cnt++;
        if (s_valid && out_ready) begin
            bx = beat_n % SW;
            by = beat_n / SW;
            check("beat_colour", 32'(s_col), {8'h00, tag, 8'(by), 8'(bx)});
            check("beat_first", 32'(s_first), 32'(beat_n == 0));
            check("beat_last_x", 32'(s_lx), 32'(bx == SW-1));
            check("beat_last_y", 32'(s_ly), 32'(beat_n == SW*SH-1));
            beat_n++;
        end
        @(posedge clk);
        #1;
        eng_update();
    endtask

    task automatic prepare(input logic [7:0] t);
        tag = t; beat_n = 0; fd_cnt = 0; start_cnt = 0;
    endtask

    task automatic run_to_done(input int budget);
        int cyc;
        cyc = 0;
        while (fd_cnt == 0 && cyc < budget) begin
            step();
            cyc++;
        end
        step();
        step();
        sample();
        check("frame_beats", beat_n, SW*SH);
        check("frame_done_count", fd_cnt, 1);
        check("busy_after_frame", 32'(s_busy), 0);
    endtask

    initial begin
        int cyc, vcnt;
        for (int k = 0; k < 4; k++) begin dly[k] = 2; cnt[k] = 0; code[k] = '0; end

        // Reset state
        step(); step();
        check("rst_busy", 32'(busy), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_eng_start", 32'(eng_start), 0);
        check("rst_eng_x", eng_x, 0);
        check("rst_eng_y", eng_y, 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_colour", 32'(out_colour), 0);
        check("rst_out_first", 32'(out_first), 0);
        check("rst_out_last_x", 32'(out_last_x), 0);
        check("rst_out_last_y", 32'(out_last_y), 0);
        check("rst_out_valid1", 32'(out_valid1), 0);
        reset = 1'b0;
        step();

        // Nominal frame
        prepare(8'h00); out_ready = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        run_to_done(200);

        // Out-of-order completion
        dly[0] = 6; dly[1] = 1;
        prepare(8'h11);
        start = 1'b1; step(); start = 1'b0;
        run_to_done(300);
        dly[0] = 2; dly[1] = 2;

        // Backpressure: stall 20 cycles once the first slot fills
        prepare(8'h22); out_ready = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 50) begin step(); cyc++; end
        check("bp_valid_seen", 32'(out_valid), 1);
        for (int i = 0; i < 20; i++) begin
            sample();
            check("bp_valid_held", 32'(s_valid), 1);
            check("bp_colour_held", 32'(s_col), {8'h00, tag, 16'h0000});
            check("bp_first_held", 32'(s_first), 1);
            step();
        end
        check("bp_outstanding", start_cnt, 4);
        out_ready = 1'b1;
        run_to_done(300);

        // Ignored events: stray done in IDLE, done with own start, start during RUN
        prepare(8'h33);
        inj_mask = 4'hF; step(); inj_mask = 4'h0;
        repeat (3) step();
        sample();
        check("ign_idle_valid", 32'(s_valid), 0);
        check("ign_idle_busy", 32'(s_busy), 0);
        junk_start = 4'b0100;
        start = 1'b1; step(); start = 1'b0;
        repeat (6) step();
        start = 1'b1; step(); start = 1'b0;
        run_to_done(300);
        check("ign_junk_consumed", 32'(junk_start), 0);

        // Reset mid-frame after 5 beats
        for (int k = 0; k < 4; k++) dly[k] = 4;
        prepare(8'h44);
        start = 1'b1; step(); start = 1'b0;
        cyc = 0;
        while (beat_n < 5 && cyc < 100) begin step(); cyc++; end
        check("mid_beats_before_reset", beat_n, 5);
        out_ready = 1'b0; step();
        reset = 1'b1; step(); reset = 1'b0;
        sample();
        check("mid_rst_valid", 32'(s_valid), 0);
        check("mid_rst_busy", 32'(s_busy), 0);
        out_ready = 1'b1;
        vcnt = 0;
        repeat (8) begin
            step();
            if (s_valid) vcnt++;
        end
        check("late_done_no_beat", vcnt, 0);
        for (int k = 0; k < 4; k++) dly[k] = 2;
        prepare(8'h55);
        start = 1'b1; step(); start = 1'b0;
        run_to_done(200);

        // Single engine
        sel = 1;
        prepare(8'h66);
        start1 = 1'b1; step(); start1 = 1'b0;
        run_to_done(400);
        check("single_start_count", start_cnt, SW*SH);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pixel_dispatch_scheduler.md
PIXEL_DISPATCH_SCHEDULER -- requirements
Module: pixel_dispatch_scheduler

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of pixel coordinate buses.
REQ-002 Parameter RGB_SIZE, default 24: width of one colour word.
REQ-003 Parameter SCREEN_WIDTH, default 640: pixels per line.
REQ-004 Parameter SCREEN_HEIGHT, default 480: lines per frame.
REQ-005 Parameter NUM_ENGINES, default 4: number of pixel compute engines sharing this scheduler; range 1..8.
REQ-006 clk  input  1  clock; all state changes on rising edge.
REQ-007 reset  input  1  reset, synchronous, active-high.
REQ-008 start  input  1  one-cycle frame start request.
REQ-009 busy  output  1  high whenever the state is not IDLE.
REQ-010 frame_done  output  1  one-cycle pulse when the last pixel of a frame is accepted downstream.
REQ-011 eng_start  output  NUM_ENGINES  one-hot, one-cycle dispatch pulse per engine.
REQ-012 eng_x / eng_y  output  DATA_WIDTH each  shared coordinate bus; valid while any eng_start bit is high.
REQ-013 eng_done  input  NUM_ENGINES  per-engine one-cycle result strobe.
REQ-014 eng_colour  input  NUM_ENGINES*RGB_SIZE  per-engine result; slice k is [k*RGB_SIZE +: RGB_SIZE], sampled when eng_done[k] is high.
REQ-015 out_valid / out_ready  output / input  1 each  downstream stream handshake.
REQ-016 out_colour  output  RGB_SIZE  pixel colour in raster order.
REQ-017 out_first / out_last_x / out_last_y  output  1 each  frame-start, end-of-line and end-of-frame flags, qualified by out_valid.

Function
REQ-018 FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN on start; this clears the dispatch coordinate to (0,0) and both the dispatch and retire pointers to 0.
- start is ignored outside IDLE.
REQ-019 Each engine k has a slot state EMPTY, BUSY or FULL.
- EMPTY -> BUSY on the edge that raises eng_start[k].
- BUSY -> FULL on eng_done[k]; eng_colour slice k is captured into slot k.
- FULL -> EMPTY on output transfer.
- eng_done[k] is ignored when slot k is not BUSY.
REQ-020 Dispatch in RUN:
- If the registered state of slot[dispatch_ptr] is EMPTY, the next cycle shows eng_start[dispatch_ptr]=1 for exactly one cycle, with eng_x/eng_y set to the current coordinate.
- At most one dispatch per cycle.
- eng_start, eng_x and eng_y are registered.
REQ-021 After each dispatch:
- The coordinate advances in raster order: x+1; if x==SCREEN_WIDTH-1, x=0 and y+1.
- dispatch_ptr advances modulo NUM_ENGINES.
REQ-022 Dispatching (SCREEN_WIDTH-1, SCREEN_HEIGHT-1) moves the FSM RUN -> DRAIN; no further dispatches occur in the frame.
REQ-023 Retire:
- out_valid = (slot[retire_ptr]==FULL) and state in {RUN, DRAIN}.
- out_colour is the stored colour of that slot.
- Transfer occurs when out_valid && out_ready; retire_ptr then advances modulo NUM_ENGINES.
REQ-024 While out_valid=1 and out_ready=0, out_colour and all flags hold stable.
REQ-025 A retire coordinate counter tracks the pixel being output:
- out_first=1 at (0,0).
- out_last_x=1 when x==SCREEN_WIDTH-1.
- out_last_y=1 only at (SCREEN_WIDTH-1, SCREEN_HEIGHT-1).
REQ-026 Output order is strict raster order regardless of eng_done order; an engine finishing early waits in FULL until its turn.
REQ-027 A slot freed by a transfer is dispatchable from the following cycle, never in the same cycle.
REQ-028 DRAIN -> DONE on the transfer with out_last_y=1.
- DONE asserts frame_done for one cycle, then goes to IDLE.
REQ-029 Outstanding dispatched-but-unretired pixels never exceed NUM_ENGINES.

Reset
REQ-030 Reset sets:
- state IDLE and all slots EMPTY;
- pointers and both coordinate counters 0;
- eng_start, out_valid, out_first, out_last_x, out_last_y, frame_done and busy 0;
- eng_x, eng_y and out_colour 0.
REQ-031 Reset mid-frame abandons the frame. eng_done strobes arriving after reset are ignored, and the next start begins at (0,0).

Verification
(All scenarios use NUM_ENGINES=4, SCREEN_WIDTH=8, SCREEN_HEIGHT=2.)
REQ-032 Nominal frame: reset, start, each engine returns done 2 cycles after its pulse with colour = {y,x} code, out_ready=1.
- Required: 16 beats in raster order.
- out_first on beat 1; out_last_x on beats 8 and 16; out_last_y on beat 16 only.
- Exactly one frame_done; busy low afterwards.
REQ-033 Out-of-order completion: engine 1 done 1 cycle after its start, engine 0 done 6 cycles after its start.
- Required: the beat carrying (0,0) is output first, then (1,0); no extra or missing beats.
REQ-034 Backpressure: out_ready=0 for 20 cycles after the first FULL slot.
- Required: out_valid held with stable payload.
- eng_start stops after 4 outstanding dispatches; all 16 pixels are delivered once ready returns.
REQ-035 Ignored events:
- start pulsed during RUN: no restart.
- eng_done on an EMPTY engine: no output beat and no slot change.
- eng_done in the same cycle as the engine's own eng_start pulse: ignored.
REQ-036 Reset mid-frame after 5 beats: out_valid=0 and busy=0 next cycle; a late eng_done is ignored; the next start produces first beat (0,0) with out_first=1.
REQ-037 NUM_ENGINES=1: strictly serial dispatch/retire; 16 beats and frame_done as in REQ-032.
